// File: rtl/stack_alu_seq.sv
// stack_alu_seq: sequential stack ALU with a valid/ready command port.
// Keeps a DEPTH-entry operand stack and executes NOP/ADD/MUL/PUSH/POP as
// true stack operations, reporting each result with a one-cycle out_valid.
// MUL is an iterative shift-add that takes N cycles.
// Optional feature macro: STACK_ALU_SUB_EN enables opcode 011 as SUB (A-B).
module stack_alu_seq #(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   opcode,
    input  logic [N-1:0]                 input_data,
    output logic                         out_valid,
    output logic [N-1:0]                 output_data,
    output logic                         overflow,
    output logic                         error,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;
`ifdef STACK_ALU_SUB_EN
    localparam logic [2:0] OP_SUB  = 3'b011;
`endif

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t            state;
    logic [N-1:0]      mem [DEPTH];
    logic [CW-1:0]     sp;
    logic [CW-1:0]     sp_nxt;

    logic [AW-1:0]     addr_a;
    logic [AW-1:0]     addr_b;
    logic [N-1:0]      a;
    logic [N-1:0]      b;
    logic              ge2;
    logic              is_full;
    logic              is_empty;

    logic              accept;
    logic              cmd_rej;
    logic              start_mul;
    logic [N-1:0]      res_data;
    logic              res_ovf;
    logic [N:0]        sum;
`ifdef STACK_ALU_SUB_EN
    logic [N:0]        diff;
`endif

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [N-1:0]      wr_data;

    logic [2*N-1:0]    mcand;
    logic [N-1:0]      mplier;
    logic [2*N-1:0]    acc;
    logic [2*N-1:0]    acc_nxt;
    logic [N-1:0]      step;
    logic              last_step;

    // Operand addressing; indices are clamped so they never wrap below zero
    assign ge2      = (sp >= CW'(2));
    assign is_full  = (sp == CW'(DEPTH));
    assign is_empty = (sp == '0);
    assign addr_a   = ge2 ? AW'(sp - CW'(2)) : '0;
    assign addr_b   = is_empty ? '0 : AW'(sp - CW'(1));
    assign a        = mem[addr_a];
    assign b        = mem[addr_b];
    assign accept   = in_valid && in_ready;
    assign count    = sp;

    assign last_step = (step == N'(N - 1));
    assign acc_nxt   = acc + (mplier[0] ? mcand : '0);

    // Command decode: rejection, result fields, stack write and next pointer
    always_comb begin
        cmd_rej   = 1'b0;
        start_mul = 1'b0;
        res_data  = '0;
        res_ovf   = 1'b0;
        sum       = '0;
`ifdef STACK_ALU_SUB_EN
        diff      = '0;
`endif
        wr_en     = 1'b0;
        wr_addr   = addr_a;
        wr_data   = '0;
        sp_nxt    = sp;
        if (state == S_MUL) begin
            if (last_step) begin
                wr_en   = 1'b1;
                wr_data = acc_nxt[N-1:0];
                sp_nxt  = sp - CW'(1);
            end
        end else if (accept) begin
            case (opcode)
                OP_NOP: begin
                    res_data = is_empty ? '0 : b;
                end
                OP_ADD: begin
                    if (!ge2) begin
                        cmd_rej = 1'b1;
                    end else begin
                        sum      = {1'b0, a} + {1'b0, b};
                        res_data = sum[N-1:0];
                        res_ovf  = sum[N];
                        wr_en    = 1'b1;
                        wr_data  = sum[N-1:0];
                        sp_nxt   = sp - CW'(1);
                    end
                end
`ifdef STACK_ALU_SUB_EN
                OP_SUB: begin
                    if (!ge2) begin
                        cmd_rej = 1'b1;
                    end else begin
                        diff     = {1'b0, a} - {1'b0, b};
                        res_data = diff[N-1:0];
                        res_ovf  = (a < b);
                        wr_en    = 1'b1;
                        wr_data  = diff[N-1:0];
                        sp_nxt   = sp - CW'(1);
                    end
                end
`endif
                OP_MUL: begin
                    if (!ge2) begin
                        cmd_rej = 1'b1;
                    end else begin
                        start_mul = 1'b1;
                    end
                end
                OP_PUSH: begin
                    if (is_full) begin
                        cmd_rej = 1'b1;
                    end else begin
                        res_data = input_data;
                        wr_en    = 1'b1;
                        wr_addr  = AW'(sp);
                        wr_data  = input_data;
                        sp_nxt   = sp + CW'(1);
                    end
                end
                OP_POP: begin
                    if (is_empty) begin
                        cmd_rej = 1'b1;
                    end else begin
                        res_data = b;
                        sp_nxt   = sp - CW'(1);
                    end
                end
                default: begin
                    cmd_rej = 1'b1;
                end
            endcase
        end
    end

    // Stack storage; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Control FSM, shift-add multiplier and registered result fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            output_data <= '0;
            overflow    <= 1'b0;
            error       <= 1'b0;
            full        <= 1'b0;
            empty       <= 1'b1;
            sp          <= '0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            step        <= '0;
        end else begin
            out_valid <= 1'b0;
            sp        <= sp_nxt;
            full      <= (sp_nxt == CW'(DEPTH));
            empty     <= (sp_nxt == '0);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (start_mul) begin
                            state    <= S_MUL;
                            in_ready <= 1'b0;
                            mcand    <= {{N{1'b0}}, a};
                            mplier   <= b;
                            acc      <= '0;
                            step     <= '0;
                        end else begin
                            out_valid   <= 1'b1;
                            output_data <= res_data;
                            overflow    <= res_ovf;
                            error       <= cmd_rej;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    step   <= step + N'(1);
                    if (last_step) begin
                        state       <= S_IDLE;
                        in_ready    <= 1'b1;
                        out_valid   <= 1'b1;
                        output_data <= acc_nxt[N-1:0];
                        overflow    <= |acc_nxt[2*N-1:N];
                        error       <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_alu_seq.sv
// Directed scoreboard bench for stack_alu_seq (N=4, DEPTH=16).
module tb_stack_alu_seq;

    localparam int N     = 4;
    localparam int DEPTH = 16;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] RSV1 = 3'b001;
    localparam logic [2:0] RSV2 = 3'b010;
    localparam logic [2:0] SUB  = 3'b011;
    localparam logic [2:0] ADD  = 3'b100;
    localparam logic [2:0] MUL  = 3'b101;
    localparam logic [2:0] PUSH = 3'b110;
    localparam logic [2:0] POP  = 3'b111;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   opcode;
    logic [N-1:0] input_data;
    logic         out_valid;
    logic [N-1:0] output_data;
    logic         overflow;
    logic         error;
    logic         full;
    logic         empty;
    logic [4:0]   count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int    d;
        int    o;
        int    e;
        int    c;
        string name;
    } exp_t;

    exp_t sb[$];

    stack_alu_seq #(.N(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .input_data  (input_data),
        .out_valid   (out_valid),
        .output_data (output_data),
        .overflow    (overflow),
        .error       (error),
        .full        (full),
        .empty       (empty),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every out_valid pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk({x.name, ".data"},  int'(output_data), x.d);
                chk({x.name, ".ovf"},   int'(overflow),    x.o);
                chk({x.name, ".err"},   int'(error),       x.e);
                chk({x.name, ".count"}, int'(count),       x.c);
                chk({x.name, ".full"},  int'(full),        (x.c == DEPTH) ? 1 : 0);
                chk({x.name, ".empty"}, int'(empty),       (x.c == 0) ? 1 : 0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(input string name, input logic [2:0] op, input int din,
                         input bit expect_out, input int d, input int o, input int e, input int c);
        int w;
        exp_t x;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk({name, ".ready_timeout"}, 0, 1);
            return;
        end
        opcode     = op;
        input_data = N'(din);
        in_valid   = 1'b1;
        if (expect_out) begin
            x.d = d; x.o = o; x.e = e; x.c = c; x.name = name;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    initial begin
        int lo;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        opcode     = '0;
        input_data = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst.in_ready",    int'(in_ready),    1);
        chk("rst.out_valid",   int'(out_valid),   0);
        chk("rst.output_data", int'(output_data), 0);
        chk("rst.overflow",    int'(overflow),    0);
        chk("rst.error",       int'(error),       0);
        chk("rst.full",        int'(full),        0);
        chk("rst.empty",       int'(empty),       1);
        chk("rst.count",       int'(count),       0);
        rst_n = 1'b1;

        // Rejections on an empty/short stack, basic ADD and POP
        issue("pop_empty", POP,  0, 1, 0, 0, 1, 0);
        issue("push3",     PUSH, 3, 1, 3, 0, 0, 1);
        issue("add_short", ADD,  0, 1, 0, 0, 1, 1);
        issue("push5",     PUSH, 5, 1, 5, 0, 0, 2);
        issue("nop_top",   NOP,  0, 1, 5, 0, 0, 2);
        issue("add_3_5",   ADD,  0, 1, 8, 0, 0, 1);
        issue("pop_8",     POP,  0, 1, 8, 0, 0, 0);
        issue("nop_empty", NOP,  0, 1, 0, 0, 0, 0);
        issue("rsv001",    RSV1, 0, 1, 0, 0, 1, 0);
        issue("rsv010",    RSV2, 0, 1, 0, 0, 1, 0);
        issue("mul_short", MUL,  0, 1, 0, 0, 1, 0);

        // MUL 15*15 = 0xE1 and its busy window
        issue("push15a", PUSH, 15, 1, 15, 0, 0, 1);
        issue("push15b", PUSH, 15, 1, 15, 0, 0, 2);
        issue("mul_15_15", MUL, 0, 1, 1, 1, 0, 1);
        lo = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
            lo++;
        end
        chk("mul.busy_cycles", lo, N);
        issue("pop_1", POP, 0, 1, 1, 0, 0, 0);

        // ADD carry out and a non-overflowing MUL
        issue("push9a",  PUSH, 9, 1, 9, 0, 0, 1);
        issue("push9b",  PUSH, 9, 1, 9, 0, 0, 2);
        issue("add_9_9", ADD,  0, 1, 2, 1, 0, 1);
        issue("push5m",  PUSH, 5, 1, 5, 0, 0, 2);
        issue("mul_2_5", MUL,  0, 1, 10, 0, 0, 1);
        issue("pop_10",  POP,  0, 1, 10, 0, 0, 0);

        // Opcode 011: SUB when enabled, otherwise reserved
        issue("push3s", PUSH, 3, 1, 3, 0, 0, 1);
        issue("push5s", PUSH, 5, 1, 5, 0, 0, 2);
`ifdef STACK_ALU_SUB_EN
        issue("sub_3_5", SUB, 0, 1, 14, 1, 0, 1);
        issue("pop_14",  POP, 0, 1, 14, 0, 0, 0);
`else
        issue("sub_rsv", SUB, 0, 1, 0, 0, 1, 2);
        issue("pop_5s",  POP, 0, 1, 5, 0, 0, 1);
        issue("pop_3s",  POP, 0, 1, 3, 0, 0, 0);
`endif
        drain();

        // Fill to DEPTH, overflowing PUSH, then POP and MUL from a full stack
        for (int i = 0; i < DEPTH; i++) begin
            issue($sformatf("fill%0d", i), PUSH, i, 1, i, 0, 0, i + 1);
        end
        drain();
        chk("full_flag", int'(full), 1);
        issue("push_full", PUSH, 7, 1, 0, 0, 1, 16);
        issue("pop_16th",  POP,  0, 1, 15, 0, 0, 15);
        issue("mul_13_14", MUL,  0, 1, 6, 1, 0, 14);
        drain();

        // Reset mid-MUL: aborted command must not report
        do_reset();
        issue("push2r", PUSH, 2, 1, 2, 0, 0, 1);
        issue("push3r", PUSH, 3, 1, 3, 0, 0, 2);
        issue("mul_abort", MUL, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort.count",     int'(count),     0);
        chk("abort.in_ready",  int'(in_ready),  1);
        chk("abort.out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort.empty", int'(empty), 1);
        issue("push4_after", PUSH, 4, 1, 4, 0, 0, 1);
        drain();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
